dm01_break_sched: RTL

Data-break scheduler for positive-bus peripherals on the PDP-8/I. Arbitrates up to NCH device channels requesting single- or three-cycle data breaks and sequences one break at a time onto the positive-bus break lines. Those lines pass through the bus level converter to the CPU. Returns read data, completion and word-count-overflow status to the winning channel.

---
 rtl/dm01_break_sched_pkg.sv | 45 ++++
 rtl/dm01_break_sched_if.sv | 63 ++++++
 rtl/dm01_break_sched_arb.sv | 31 +++
 rtl/dm01_break_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dm01_break_sched_pkg.sv
// dm01_break_sched shared types and constants.
// Positive-bus break scheduler for PDP-8/I peripherals.
package dm01_pkg;

  localparam int WORD_W = 12;
  localparam int EA_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_e;

  typedef struct packed {
    logic              dir;
    logic              cyc3;
    logic [EA_W-1:0]   ea;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } brk_t;

  typedef struct packed {
    logic              brk_rq_l;
    logic              data_in_l;
    logic              cyc3_l;
    logic              ca_inc_h;
    logic              mb_inc_l;
    logic [WORD_W-1:0] da_l;
    logic [EA_W-1:0]   ea_l;
    logic [WORD_W-1:0] d_l;
  } pb_out_t;

  localparam pb_out_t PB_IDLE = '{
    brk_rq_l:  1'b1,
    data_in_l: 1'b1,
    cyc3_l:    1'b1,
    ca_inc_h:  1'b0,
    mb_inc_l:  1'b1,
    da_l:      '1,
    ea_l:      '1,
    d_l:       '1
  };

endpackage

// File: rtl/dm01_break_sched_if.sv
// Channel and positive-bus bundle for dm01_break_sched.
// master = channels + CPU side, slave = scheduler.
interface dm01_break_sched_if #(
  parameter int NCH = 4
);
  import dm01_pkg::*;

  logic [NCH-1:0]        chan_req;
  logic [NCH-1:0]        chan_dir;
  logic [NCH-1:0]        chan_3cyc;
  logic [NCH*WORD_W-1:0] chan_addr;
  logic [NCH*EA_W-1:0]   chan_ea;
  logic [NCH*WORD_W-1:0] chan_wdata;
  logic [NCH-1:0]        chan_gnt;
  logic [NCH-1:0]        chan_done;
  logic [NCH-1:0]        chan_wco;
  logic [WORD_W-1:0]     chan_rdata;

  logic              pb_brk_rq_l;
  logic              pb_data_in_l;
  logic              pb_3_cycle_l;
  logic              pb_ca_inc_h;
  logic              pb_mb_inc_l;
  logic [WORD_W-1:0] pb_da_l;
  logic [EA_W-1:0]   pb_ea_l;
  logic [WORD_W-1:0] pb_d_l;

  logic              pb_run_l;
  logic              pb_add_accept_l;
  logic              pb_break_l;
  logic              pb_wc_overflow_l;
  logic              pb_ts3_h;
  logic [WORD_W-1:0] pb_bmb_h;

  modport master (
    output chan_req, chan_dir, chan_3cyc,
    output chan_addr, chan_ea, chan_wdata,
    input  chan_gnt, chan_done, chan_wco,
    input  chan_rdata,
    input  pb_brk_rq_l, pb_data_in_l,
    input  pb_3_cycle_l, pb_ca_inc_h,
    input  pb_mb_inc_l, pb_da_l,
    input  pb_ea_l, pb_d_l,
    output pb_run_l, pb_add_accept_l,
    output pb_break_l, pb_wc_overflow_l,
    output pb_ts3_h, pb_bmb_h
  );

  modport slave (
    input  chan_req, chan_dir, chan_3cyc,
    input  chan_addr, chan_ea, chan_wdata,
    output chan_gnt, chan_done, chan_wco,
    output chan_rdata,
    output pb_brk_rq_l, pb_data_in_l,
    output pb_3_cycle_l, pb_ca_inc_h,
    output pb_mb_inc_l, pb_da_l,
    output pb_ea_l, pb_d_l,
    input  pb_run_l, pb_add_accept_l,
    input  pb_break_l, pb_wc_overflow_l,
    input  pb_ts3_h, pb_bmb_h
  );

endinterface

// File: rtl/dm01_break_sched_arb.sv
// Combinational break arbiter: fixed priority
// from channel 0, or round-robin from ptr_i.
module break_arb #(
  parameter int NCH    = 4,
  parameter bit ROTATE = 1'b0,
  parameter int PW     = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o
);

  int   base;
  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    base  = ROTATE ? int'(ptr_i) : 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (base + k) % NCH;
      if (req_i[idx] && !found) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm01_break_sched.sv
// Data-break scheduler: arbitrates channels and
// sequences one break at a time onto the positive bus.
module dm01_break_sched
  import dm01_pkg::*;
#(
  parameter int NCH    = 4,
  parameter bit ROTATE = 1'b0
) (
  input logic              clk,
  input logic              reset_l,
  dm01_break_sched_if.slave io
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  // {ts3, wc_overflow_l, break_l, add_accept_l, run_l}
  localparam logic [4:0] SYNC_IDLE = 5'b01111;

  state_e            state_q, state_d;
  logic [NCH-1:0]    gnt_q, gnt_d;
  logic [NCH-1:0]    done_q, done_d;
  logic [NCH-1:0]    wco_q, wco_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  brk_t              brk_q, brk_d;

  logic [4:0]     pb_in, s1_q, s2_q, s3_q;
  logic [NCH-1:0] win;
  brk_t           sel;
  logic [PW-1:0]  gidx, ptr_nxt;
  logic           run_s, aa_fall, aa_hi;
  logic           brk_hi, wco_s, ts3_rise;
  pb_out_t        pb;

  assign pb_in = {io.pb_ts3_h, io.pb_wc_overflow_l,
                  io.pb_break_l, io.pb_add_accept_l,
                  io.pb_run_l};

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_q <= SYNC_IDLE;
      s2_q <= SYNC_IDLE;
      s3_q <= SYNC_IDLE;
    end else begin
      s1_q <= pb_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign run_s    = !s2_q[0];
  assign aa_hi    = s2_q[1];
  assign aa_fall  = !s2_q[1] && s3_q[1];
  assign brk_hi   = s2_q[2];
  assign wco_s    = !s2_q[3];
  assign ts3_rise = s2_q[4] && !s3_q[4];

  break_arb #(
    .NCH    (NCH),
    .ROTATE (ROTATE),
    .PW     (PW)
  ) u_arb (
    .req_i (io.chan_req),
    .ptr_i (ptr_q),
    .gnt_o (win)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win[i]) begin
        sel.dir   = io.chan_dir[i];
        sel.cyc3  = io.chan_3cyc[i];
        sel.ea    = io.chan_ea[i*EA_W +: EA_W];
        sel.addr  = io.chan_addr[i*WORD_W +: WORD_W];
        sel.wdata = io.chan_wdata[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_q[i]) gidx = PW'(i);
    end
  end

  assign ptr_nxt = (int'(gidx) == NCH - 1) ?
                   '0 : gidx + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    brk_d   = brk_q;
    done_d  = '0;
    wco_d   = '0;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_s && |io.chan_req) begin
          gnt_d   = win;
          brk_d   = sel;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!run_s) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (aa_fall) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (ts3_rise) begin
          rdata_d = io.pb_bmb_h;
          done_d  = gnt_q;
          wco_d   = wco_s ? gnt_q : '0;
          ptr_d   = ptr_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d = '0;
        // hold until the CPU has left this break
        if (brk_hi && aa_hi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      wco_q   <= '0;
      rdata_q <= '0;
      ptr_q   <= '0;
      brk_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      wco_q   <= wco_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    pb = PB_IDLE;
    if (state_q != S_IDLE) begin
      pb.brk_rq_l  = (state_q != S_REQ);
      pb.data_in_l = !brk_q.dir;
      pb.cyc3_l    = !brk_q.cyc3;
      pb.ca_inc_h  = brk_q.cyc3;
      pb.da_l      = ~brk_q.addr;
      pb.ea_l      = ~brk_q.ea;
      pb.d_l       = ~brk_q.wdata;
    end
  end

  assign io.pb_brk_rq_l  = pb.brk_rq_l;
  assign io.pb_data_in_l = pb.data_in_l;
  assign io.pb_3_cycle_l = pb.cyc3_l;
  assign io.pb_ca_inc_h  = pb.ca_inc_h;
  assign io.pb_mb_inc_l  = pb.mb_inc_l;
  assign io.pb_da_l      = pb.da_l;
  assign io.pb_ea_l      = pb.ea_l;
  assign io.pb_d_l       = pb.d_l;

  assign io.chan_gnt   = gnt_q;
  assign io.chan_done  = done_q;
  assign io.chan_wco   = wco_q;
  assign io.chan_rdata = rdata_q;

endmodule
